multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the CPU datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with a req/ready handshake to the shared instruction/data memory port. Drives the PC, IR, MDR, register-file and memory enables; the per-opcode ALU and operand selects stay in the combinational decoder. Adds a memory-wait timeout, an illegal-opcode trap and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles on one memory access before trapping (>=2)
RET_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  4  IR[31:28]; valid from DECODE onward
aluCond  in  1  ALU compare result; sampled in EXEC for BCOND
memReady  in  1  memory ack; qualifies the current memReq
memReq  out  1  memory access request
memWe  out  1  write strobe; valid only with memReq
memAddrSel  out  1  0 = PC, 1 = ALU result
irWrEn  out  1  load IR from memory read data
mdrWrEn  out  1  load MDR from memory read data (LW)
regWrEn  out  1  register-file write
regWrSel  out  2  00 ALU, 01 MEM, 10 PC
pcWrEn  out  1  PC update, exactly one pulse per retired instruction
pcSel  out  2  00 next, 01 imm, 10 ALU
trap  out  1  sticky; controller halted
trapCause  out  2  00 none, 01 illegal opcode, 10 memory timeout
retired  out  RET_W  count of retired instructions, wraps

Behaviour:
- Opcodes: ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001, JAL 1011; all others illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State and opReg are registered; outputs are Moore decodes of the state, plus opReg, memReady and aluCond where stated.
- Reset (async, any state, including mid-handshake): state=IDLE, opReg=0, waitCnt=0, retired=0, trapCause=00. All outputs are 0 while reset_n is low and in IDLE. IDLE moves to FETCH on the first clock edge after release.
- FETCH: memReq=1, memAddrSel=0, memWe=0. irWrEn=memReady. Moves to DECODE on the edge where memReady=1. Zero-wait (ready in the first cycle) is legal.
- DECODE: opReg<=opcode. Illegal opcode goes to TRAP with cause 01; otherwise goes to EXEC.
- EXEC:
  - BCOND: pcWrEn=1, pcSel = aluCond ? 01 : 00, then FETCH.
  - SW and LW: go to MEM.
  - All other legal opcodes: go to WB.
- MEM: memReq=1, memAddrSel=1, memWe=(opReg==SW). Held until memReady=1.
  - SW: pcWrEn=1 and pcSel=00 in the ready cycle, then FETCH.
  - LW: mdrWrEn=1 in the ready cycle, then WB.
- WB: regWrEn=1 and pcWrEn=1.
  - regWrSel: LW 01, JAL 10, otherwise 00.
  - pcSel: JAL 10, otherwise 00.
  - Next state is FETCH.
- Handshake: memReq and memWe stay stable until the ready edge. memReady while memReq=0 is ignored.
- Timeout: waitCnt clears on entry to FETCH or MEM and increments each cycle memReady=0 in those states. If waitCnt==MEM_TIMEOUT-1 and memReady=0, go to TRAP with cause 10. memReady in that same cycle wins and the access completes.
- TRAP: all enables 0, trap=1, cause held; exits only via reset.
- retired increments (wrapping at 2^RET_W) on every cycle where pcWrEn=1.
- Cycles per instruction at zero wait: ALU/CMP/JAL 4, BCOND 3, SW 4, LW 5. Each memory wait state adds 1.

Decomposition:
- cpu_pkg holds the opcode constants, RD_ALU/RD_MEM/RD_PC, PC_NEXT/PC_IMM/PC_ALU, the state encoding and the trap-cause encodings. The decoder shares these.
- Sub-module mem_wait_timer (waitCnt, clear/enable inputs, timeout flag, parameter MEM_TIMEOUT).

Test Plan:
- Reset, then ALUI with memReady tied 1 -> FETCH..WB in 4 cycles; regWrEn=1 and regWrSel=00 in cycle 4; pcWrEn pulses once; retired=1.
- BCOND with aluCond=1, then BCOND with aluCond=0 -> 3 cycles each; pcSel=01 then 00 in EXEC; no regWrEn; retired=2.
- LW with memReady low for 3 cycles in MEM -> memReq/memAddrSel=1 held for 4 cycles; mdrWrEn on the ready cycle; WB has regWrSel=01; total 8 cycles.
- SW then JAL -> memWe=1 only in MEM of SW; JAL WB has regWrSel=10 and pcSel=10.
- Opcode 1111 -> TRAP after DECODE, trapCause=01; memReq stays 0 for 20 further cycles.
- FETCH with memReady stuck low (MEM_TIMEOUT=16) -> trap asserts on the 17th cycle with cause 10. Repeat with ready in the 16th wait cycle -> no trap. Pulse reset_n low mid-MEM -> all outputs 0 immediately, restart from IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, select, state and trap-cause encodings shared by control and decoder
package cpu_pkg;

    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_BCOND = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1011;

    localparam logic [1:0] RD_ALU = 2'b00;
    localparam logic [1:0] RD_MEM = 2'b01;
    localparam logic [1:0] RD_PC  = 2'b10;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;
    localparam logic [1:0] PC_ALU  = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI,
            OP_BCOND, OP_SW, OP_LW, OP_JAL: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts consecutive memory wait cycles and flags the last allowed one
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT);

    logic [CW-1:0] wait_cnt_q;

    // Wait counter: restarts on every state entry, advances while the access is stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (clr) begin
            wait_cnt_q <= '0;
        end else if (en) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end
    end

    assign timeout = (wait_cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic             aluCond,
    input  logic             memReady,
    output logic             memReq,
    output logic             memWe,
    output logic             memAddrSel,
    output logic             irWrEn,
    output logic             mdrWrEn,
    output logic             regWrEn,
    output logic [1:0]       regWrSel,
    output logic             pcWrEn,
    output logic [1:0]       pcSel,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [RET_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       cause_q, cause_d;
    logic [RET_W-1:0] retired_q;
    logic             timeout;
    logic             wait_clr;
    logic             wait_en;

    // Any state change restarts the wait count, so each FETCH/MEM visit gets a fresh budget
    assign wait_clr = (state_d != state_q);
    assign wait_en  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !memReady;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (wait_clr),
        .en     (wait_en),
        .timeout(timeout)
    );

    // State, latched opcode and sticky trap cause
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cause_q <= TC_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cause_q <= cause_d;
        end
    end

    // Retired-instruction counter: one PC write per retired instruction, wraps freely
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
        end else if (pcWrEn) begin
            retired_q <= retired_q + RET_W'(1);
        end
    end

    // Next-state and Moore outputs; memReady/aluCond only qualify ready and branch cycles
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cause_d    = cause_q;
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddrSel = 1'b0;
        irWrEn     = 1'b0;
        mdrWrEn    = 1'b0;
        regWrEn    = 1'b0;
        regWrSel   = RD_ALU;
        pcWrEn     = 1'b0;
        pcSel      = PC_NEXT;
        trap       = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                memReq = 1'b1;
                irWrEn = memReady;
                if (memReady) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (op_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_BCOND: begin
                        pcWrEn  = 1'b1;
                        pcSel   = aluCond ? PC_IMM : PC_NEXT;
                        state_d = ST_FETCH;
                    end
                    OP_SW, OP_LW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                memReq     = 1'b1;
                memAddrSel = 1'b1;
                memWe      = (op_q == OP_SW);
                if (memReady) begin
                    if (op_q == OP_SW) begin
                        pcWrEn  = 1'b1;
                        pcSel   = PC_NEXT;
                        state_d = ST_FETCH;
                    end else begin
                        mdrWrEn = 1'b1;
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end
            ST_WB: begin
                regWrEn  = 1'b1;
                pcWrEn   = 1'b1;
                regWrSel = (op_q == OP_LW) ? RD_MEM : ((op_q == OP_JAL) ? RD_PC : RD_ALU);
                pcSel    = (op_q == OP_JAL) ? PC_ALU : PC_NEXT;
                state_d  = ST_FETCH;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign trapCause = cause_q;
    assign retired   = retired_q;

endmodule
